// File: rtl/mod_dp.sv
// -----------------------------------------------------------------------------
// mod_dp : datapath stage of the repeated-subtraction modulus unit.
//
// The control unit sequences this block with two strobes. Their meaning per
// clock edge, with reset taking priority over both, is:
//   we=0         hold every register (s is ignored)
//   we=1, s=0    load: capture dividend a and divisor b, clear quotient
//   we=1, s=1    subtract: temp -= divisor and quotient += 1, but only
//                while x is low; once x is high the registers hold.
// x is the termination flag that the control unit samples on the same edge
// that the subtract guard uses, so the two can never disagree.
//
// Ports:
//   CLK       in   system clock, rising edge
//   reset     in   synchronous, active-high reset (clears all state)
//   a         in   dividend, sampled on a load edge only
//   b         in   divisor, sampled on a load edge only
//   s         in   path select: 0 = load, 1 = subtract
//   we        in   register write enable
//   x         out  done flag, combinational from registers
//   temp      out  running remainder
//   quotient  out  subtractions performed since the last load
//   div_zero  out  latched "divisor was zero at load" status
// -----------------------------------------------------------------------------
module mod_dp #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             we,
    output logic             x,
    output logic [WIDTH-1:0] temp,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero
);

    logic [WIDTH-1:0] r_temp;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_quotient;
    logic             r_div_zero;
    logic             w_x;

    // Done when the remainder can no longer absorb another divisor, or when
    // the divisor is zero (a mod 0 is defined as a, nothing to subtract).
    assign w_x = r_div_zero | (r_temp < r_b);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_temp     <= '0;
            r_b        <= '0;
            r_quotient <= '0;
            r_div_zero <= 1'b0;
        end else if (we) begin
            if (!s) begin
                r_temp     <= a;
                r_b        <= b;
                r_quotient <= '0;
                r_div_zero <= (b == '0);
            end else if (!w_x) begin
                // Guarded: the control unit still strobes subtract on the
                // edge where it leaves the loop, which must not underflow.
                r_temp     <= r_temp - r_b;
                r_quotient <= r_quotient + 1'b1;
            end
        end
    end

    assign x        = w_x;
    assign temp     = r_temp;
    assign quotient = r_quotient;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mod_dp.sv
module tb_mod_dp;

  localparam int W = 32;

  // clock / reset block
  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         s = 1'b0;
  logic         we = 1'b0;
  logic         x;
  logic [W-1:0] temp;
  logic [W-1:0] quotient;
  logic         div_zero;

  always #5 CLK = ~CLK;

  mod_dp #(.WIDTH(W)) dut (
    .CLK(CLK), .reset(reset), .a(a), .b(b), .s(s), .we(we),
    .x(x), .temp(temp), .quotient(quotient), .div_zero(div_zero)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: remember the loaded operands and how many subtract
  // strobes were accepted; the outputs follow from arithmetic on those.
  logic [W-1:0] m_a = '0, m_b = '0, m_n = '0;
  bit           m_rst = 1'b0;
  bit           m_valid = 1'b0;

  always @(posedge CLK) begin
    if (reset) begin
      m_rst = 1'b1; m_a = '0; m_b = '0; m_n = '0; m_valid = 1'b1;
    end else if (we && !s) begin
      m_rst = 1'b0; m_a = a; m_b = b; m_n = '0;
    end else if (we && s) begin
      // After reset remainder and divisor are both 0: 0<0 is false, so a
      // subtract is accepted (temp stays 0, quotient counts).
      if (m_rst) m_n = m_n + 1;
      else if (m_b != 0 && m_n < m_a / m_b) m_n = m_n + 1;
    end
  end

  // scoreboard / compare process, sampled on the falling edge
  always @(negedge CLK) begin
    logic [W-1:0] e_temp;
    logic         e_x, e_dz;
    if (m_valid) begin
      if (m_rst) begin
        e_temp = '0; e_dz = 1'b0; e_x = 1'b0;
      end else begin
        e_dz   = (m_b == 0);
        e_x    = e_dz || (m_n == m_a / m_b);
        e_temp = e_dz ? m_a : m_a - m_n * m_b;
      end
      chk("model_temp", temp, e_temp);
      chk("model_quotient", quotient, m_n);
      chk("model_div_zero", {31'b0, div_zero}, {31'b0, e_dz});
      chk("model_x", {31'b0, x}, {31'b0, e_x});
    end
  end

  // driver tasks: apply inputs, take one edge, settle past it
  task automatic cyc(input bit r, input bit w, input bit sel,
                     input logic [W-1:0] va, input logic [W-1:0] vb);
    reset = r; we = w; s = sel; a = va; b = vb;
    @(posedge CLK);
    #2;
  endtask

  task automatic load(input logic [W-1:0] va, input logic [W-1:0] vb);
    cyc(1'b0, 1'b1, 1'b0, va, vb);
  endtask

  task automatic sub();
    cyc(1'b0, 1'b1, 1'b1, $urandom, $urandom);
  endtask

  task automatic lit(input string name, input logic [W-1:0] et, input logic [W-1:0] eq,
                     input bit ex, input bit ed);
    chk({name, "_temp"}, temp, et);
    chk({name, "_quotient"}, quotient, eq);
    chk({name, "_x"}, {31'b0, x}, {31'b0, ex});
    chk({name, "_div_zero"}, {31'b0, div_zero}, {31'b0, ed});
  endtask

  initial begin
    logic [W-1:0] t2_temp [6];
    logic [W-1:0] t2_q [6];
    t2_temp = '{32'd12, 32'd7, 32'd2, 32'd2, 32'd2, 32'd2};
    t2_q    = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3};

    #2;
    // 1: reset wins over a simultaneous load
    cyc(1'b1, 1'b1, 1'b0, 32'd7, 32'd2);
    cyc(1'b1, 1'b1, 1'b0, 32'd7, 32'd2);
    lit("reset", 32'd0, 32'd0, 1'b0, 1'b0);

    // 2: 17 mod 5
    load(32'd17, 32'd5);
    lit("t2_load", 32'd17, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sub();
      lit("t2_sub", t2_temp[i], t2_q[i], (i >= 2), 1'b0);
    end

    // 3: a < b
    load(32'd4, 32'd9);
    lit("t3_load", 32'd4, 32'd0, 1'b1, 1'b0);
    sub(); sub();
    lit("t3_hold", 32'd4, 32'd0, 1'b1, 1'b0);

    // 4: divide by zero, then recovery
    load(32'd123, 32'd0);
    lit("t4_dz", 32'd123, 32'd0, 1'b1, 1'b1);
    sub(); sub(); sub();
    lit("t4_dz_hold", 32'd123, 32'd0, 1'b1, 1'b1);
    load(32'd10, 32'd3);
    lit("t4_reload", 32'd10, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sub();
    lit("t4_done", 32'd1, 32'd3, 1'b1, 1'b0);

    // 5: extremes
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    sub();
    lit("t5_max", 32'd0, 32'd1, 1'b1, 1'b0);
    sub();
    lit("t5_max_hold", 32'd0, 32'd1, 1'b1, 1'b0);
    load(32'd0, 32'd1);
    lit("t5_zero", 32'd0, 32'd0, 1'b1, 1'b0);
    load(32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 16; i++) begin
      sub();
      chk("t5_qinc", quotient, 32'(i + 1));
    end
    chk("t5_qinc_temp", temp, 32'hFFFF_FFEF);

    // 6: mid-operation reset
    load(32'd100, 32'd3);
    for (int i = 0; i < 5; i++) sub();
    lit("t6_mid", 32'd85, 32'd5, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
    lit("t6_reset", 32'd0, 32'd0, 1'b0, 1'b0);

    // 6: mid-operation reload
    load(32'd100, 32'd3);
    for (int i = 0; i < 5; i++) sub();
    load(32'd50, 32'd7);
    lit("t6_reload", 32'd50, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sub();
    lit("t6_reload_done", 32'd1, 32'd7, 1'b1, 1'b0);

    // 6: we=0 freezes everything
    load(32'd100, 32'd3);
    sub(); sub();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
      lit("t6_freeze", 32'd94, 32'd2, 1'b0, 1'b0);
    end

    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)
        cyc(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      else if (r < 12)
        load($urandom_range(0, 300), $urandom_range(0, 25));
      else if (r < 14)
        load($urandom, $urandom);
      else if (r < 80)
        sub();
      else
        cyc(1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
    end

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
